shift_deser_31: RTL and testbench
=================================

# shift_deser_31

Serial-to-parallel receiver that reassembles 31-bit words from the LSB-first bit stream produced by the design's preset/shift-out serializer. Bits are qualified by a strobe and framed by a sync marker on the first bit of each word. Completed words are held in an output register behind a valid/ack handshake. The block sits on the receive side of the serial link, in the `qzt_clk` domain, and feeds word-level consumers such as control decoders and checkers.

## Interface
- `WORD_W`, 31: word width in bits; the counter width is ceil(log2(WORD_W+1)).
- `qzt_clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  serial data bit, LSB of the word first.
- `bit_valid`  in  1  `serial_in` carries a bit this cycle.
- `sync`  in  1  the qualified bit this cycle is bit 0 of a word; ignored unless `bit_valid`=1.
- `word_ack`  in  1  consumer accepts `word`.
- `word`  out  WORD_W  last completed word; bit 0 is the first bit received.
- `word_valid`  out  1  `word` holds an unconsumed word.
- `frame_err`  out  1  one-cycle pulse when a sync aborts a partial word.
- `overrun`  out  1  sticky: a word was overwritten before it was acked.
- `bit_cnt`  out  5  bits collected in the current word (0..30).
- `err_cnt`  out  16  word-mismatch count; exists only with the macro below.
- `expected_word`  in  WORD_W  reference for the mismatch check; exists only with the macro below.

## Operation
- FSM has two states. HUNT is the reset state. LOCK means framed.
- HUNT: qualified bits without `sync` are discarded. A qualified bit with `sync` is shifted in, `bit_cnt` becomes 1, and the FSM goes to LOCK.
- LOCK: on each qualified bit, `shreg <= {serial_in, shreg[30:1]}` and `bit_cnt` increments.
- When the 31st bit is shifted in: `word <= {serial_in, shreg[30:1]}`, `word_valid` is set, and `bit_cnt` becomes 0. The FSM stays in LOCK, so framing continues with no further sync needed.
- `sync` in LOCK with `bit_cnt`=0 is a normal word start; there is no error.
- `sync` in LOCK with `bit_cnt`≠0 discards the partial word, pulses `frame_err` for one cycle, and takes this bit as bit 0 (`bit_cnt`=1).
- `word_valid` clears on `word_ack` and otherwise holds.
- A word completing while `word_valid`=1 and `word_ack`=0 overwrites `word` and sets `overrun`. `overrun` clears only on reset.
- Word completion together with `word_ack` in the same cycle loads the new word, keeps `word_valid`=1, and does not set `overrun`.
- `word_ack` while `word_valid`=0 has no effect.
- Cycles with `bit_valid`=0 change no shift or count state.

## Timing
- Reset values: `word`=0, `word_valid`=0, `frame_err`=0, `overrun`=0, `bit_cnt`=0, `err_cnt`=0, FSM=HUNT, `shreg`=0.
- Reset asserted mid-word drops the partial word and any pending `word_valid`.
- Latency: `word` and `word_valid` update on the same edge that samples the 31st bit, so they are visible in the following cycle.
- Throughput: one word per 31 qualified bits, with `bit_valid` allowed high every cycle. Idle gaps are allowed anywhere.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- `SHIFT_DESER_ERRCNT_EN` defined:
  - Each completed word is compared against `expected_word` as sampled on the completion edge.
  - A mismatch increments `err_cnt`, which saturates at 16'hFFFF.
  - Ports `expected_word` and `err_cnt` are present.
- Undefined: both ports and the compare logic are absent. All other behaviour is identical.

## Structure
- Shared package `shift_link_pkg` holds:
  - `WORD_W`=31;
  - the FSM state enum {HUNT, LOCK};
  - the counter width constant;
  - the default preset pattern, which the serializer and its benches also use.
- Sub-module `shift_deser_errcnt` holds the comparator and saturating counter. It is instantiated only under `SHIFT_DESER_ERRCNT_EN`.

## Test plan
- Reset, then `sync`+`bit_valid` on bit 0, then 31 bits of 31'h2AAA_AAAA LSB-first with `bit_valid` held high → `word`=31'h2AAA_AAAA, `word_valid`=1 exactly one cycle after the 31st bit, `bit_cnt`=0.
- Same word with `bit_valid` deasserted every other cycle → identical `word`, and completion occurs only after the 31st qualified bit.
- After 10 bits, reassert `sync` and send a full 31'h0000_0001 → `frame_err` pulses once, then `word`=31'h0000_0001.
- Two back-to-back words (31'h1234_5678, then 31'h7FFF_FFFF) with no ack → `word`=31'h7FFF_FFFF and `overrun`=1.
- Repeat the previous case with `word_ack` on the completion cycle of the second word → `overrun`=0 and `word_valid`=1.
- With `SHIFT_DESER_ERRCNT_EN`: three words against `expected_word`=31'h1234_5678, one of them with a flipped bit → `err_cnt`=1. Assert `reset` mid-word → all outputs return to their reset values.

Source files
------------

// File: rtl/shift_link_pkg.sv
// -----------------------------------------------------------------------------
// shift_link_pkg
// Definitions shared by the serial link serializer, the deserializer and their
// benches: the word width, the bit counter width, the receive FSM state
// encoding, the default preset pattern and the LSB-first shift helper.
// -----------------------------------------------------------------------------
package shift_link_pkg;

  localparam int WORD_W = 31;
  // Wide enough to hold the values 0..WORD_W.
  localparam int CNT_W  = $clog2(WORD_W + 1);

  // Default preset pattern loaded by the serializer.
  localparam logic [WORD_W-1:0] PRESET_WORD = 31'h2AAA_AAAA;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Shift one bit in at the MSB end. Because the stream is LSB first, the first
  // bit received reaches position 0 after WORD_W shifts.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sr,
                                                 input logic              b);
    return {b, sr[WORD_W-1:1]};
  endfunction

endpackage

// File: rtl/shift_deser_errcnt.sv
// -----------------------------------------------------------------------------
// shift_deser_errcnt
// Compares each completed word against a reference word and counts the
// mismatches in a 16-bit counter that saturates at 16'hFFFF.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   wr_i        a word completes on this edge
//   word_i      the word being completed
//   expected_i  reference word, sampled on the completion edge
//   err_cnt_o   registered mismatch count
// -----------------------------------------------------------------------------
module shift_deser_errcnt
  import shift_link_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] expected_i,
  output logic [15:0]       err_cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_i && (word_i != expected_i) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/shift_deser_31.sv
// -----------------------------------------------------------------------------
// shift_deser_31
// Serial-to-parallel receiver. Reassembles 31-bit words from an LSB-first bit
// stream qualified by bit_valid and framed by a sync marker on bit 0. A
// completed word is held in an output register behind a valid/ack handshake.
//
// Optional feature: define SHIFT_DESER_ERRCNT_EN to add a mismatch counter that
// compares each completed word against expected_word (adds ports expected_word
// and err_cnt).
//
// Ports:
//   qzt_clk        clock, rising edge
//   reset          asynchronous active-high reset
//   serial_in      serial data bit, LSB first
//   bit_valid      serial_in carries a bit this cycle
//   sync           qualified bit is bit 0 of a word
//   word_ack       consumer accepts word
//   word           last completed word (bit 0 = first bit received)
//   word_valid     word holds an unconsumed word
//   frame_err      one-cycle pulse when a sync aborts a partial word
//   overrun        sticky, a word was overwritten before it was acked
//   bit_cnt        bits collected in the current word
//   expected_word  reference word (SHIFT_DESER_ERRCNT_EN only)
//   err_cnt        saturating mismatch count (SHIFT_DESER_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module shift_deser_31
  import shift_link_pkg::*;
(
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_valid,
  input  logic              sync,
  input  logic              word_ack,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  bit_cnt
`ifdef SHIFT_DESER_ERRCNT_EN
  ,
  input  logic [WORD_W-1:0] expected_word,
  output logic [15:0]       err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic [WORD_W-1:0]   shifted;
  logic                complete;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    // Ack drops the valid flag; a word completing this cycle re-sets it below.
    word_valid_d = word_valid_q & ~word_ack;
    complete     = 1'b0;
    shifted      = shift_in(shreg_q, serial_in);

    if (bit_valid) begin
      unique case (state_q)
        HUNT: begin
          // Unframed bits are thrown away until a sync marks bit 0.
          if (sync) begin
            shreg_d = shifted;
            cnt_d   = CNT_ONE;
            state_d = LOCK;
          end
        end
        LOCK: begin
          shreg_d = shifted;
          if (sync && (cnt_q != '0)) begin
            // Sync inside a partial word: restart framing at this bit.
            frame_err_d = 1'b1;
            cnt_d       = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            complete     = 1'b1;
            word_d       = shifted;
            word_valid_d = 1'b1;
            cnt_d        = '0;
            // An ack on the same edge frees the old word, so no overrun then.
            if (word_valid_q && !word_ack) begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      shreg_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign bit_cnt    = cnt_q;

`ifdef SHIFT_DESER_ERRCNT_EN
  shift_deser_errcnt u_errcnt (
    .clk_i      (qzt_clk),
    .rst_i      (reset),
    .wr_i       (complete),
    .word_i     (shifted),
    .expected_i (expected_word),
    .err_cnt_o  (err_cnt)
  );
`else
  // Without the mismatch counter the completion strobe has no consumer.
  logic unused_complete;
  assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_shift_deser_31.sv
// -----------------------------------------------------------------------------
// tb_shift_deser_31
// Directed testbench for shift_deser_31. Each scenario task drives a stimulus
// sequence and checks the outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_shift_deser_31;
  import shift_link_pkg::*;

  logic              qzt_clk = 1'b0;
  logic              reset;
  logic              serial_in;
  logic              bit_valid;
  logic              sync;
  logic              word_ack;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              frame_err;
  logic              overrun;
  logic [CNT_W-1:0]  bit_cnt;
`ifdef SHIFT_DESER_ERRCNT_EN
  logic [WORD_W-1:0] expected_word;
  logic [15:0]       err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  shift_deser_31 dut (
    .qzt_clk       (qzt_clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .bit_valid     (bit_valid),
    .sync          (sync),
    .word_ack      (word_ack),
    .word          (word),
    .word_valid    (word_valid),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .bit_cnt       (bit_cnt)
`ifdef SHIFT_DESER_ERRCNT_EN
    ,
    .expected_word (expected_word),
    .err_cnt       (err_cnt)
`endif
  );

  always #5 qzt_clk = ~qzt_clk;

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input logic b, input logic s, input logic v, input logic a);
    serial_in = b;
    sync      = s;
    bit_valid = v;
    word_ack  = a;
    @(posedge qzt_clk);
    #1;
    serial_in = 1'b0;
    sync      = 1'b0;
    bit_valid = 1'b0;
    word_ack  = 1'b0;
  endtask

  // Send bits [first..last] of w back to back; sync on bit 0 when requested,
  // ack on bit 30 when requested.
  task automatic send_bits(input logic [WORD_W-1:0] w, input int first, input int last,
                           input logic with_sync, input logic ack_last);
    for (int i = first; i <= last; i++) begin
      drive(w[i], with_sync && (i == 0), 1'b1, ack_last && (i == WORD_W - 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge qzt_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (word !== 31'h0) begin n_bad++; $display("FAIL reset_word: got %h want %h", word, 31'h0); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (bit_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
`ifdef SHIFT_DESER_ERRCNT_EN
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
  endtask

  task automatic test_hunt();
    do_reset();
    // Unframed bits are discarded.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bit_cnt !== 5'd0) begin n_bad++; $display("FAIL hunt_discard: bit_cnt got %0d want 0", bit_cnt); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bit_cnt !== 5'd1) begin n_bad++; $display("FAIL hunt_sync: bit_cnt got %0d want 1", bit_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    send_bits(31'h2AAA_AAAA, 0, 29, 1'b1, 1'b0);
    n_cmp++; if (bit_cnt !== 5'd30) begin n_bad++; $display("FAIL basic_cnt30: got %0d want 30", bit_cnt); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", word_valid); end
    send_bits(31'h2AAA_AAAA, 30, 30, 1'b0, 1'b0);
    n_cmp++; if (word !== 31'h2AAA_AAAA) begin n_bad++; $display("FAIL basic_word: got %h want %h", word, 31'h2AAA_AAAA); end
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", word_valid); end
    n_cmp++; if (bit_cnt !== 5'd0) begin n_bad++; $display("FAIL basic_cnt0: got %0d want 0", bit_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack: valid got %b want 0", word_valid); end
    // Ack while nothing is pending does nothing.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (word_valid !== 1'b0 || word !== 31'h2AAA_AAAA) begin
      n_bad++; $display("FAIL basic_idle_ack: valid %b word %h want 0 %h", word_valid, word, 31'h2AAA_AAAA);
    end
  endtask

  task automatic test_gaps();
    logic [WORD_W-1:0] w;
    w = 31'h2AAA_AAAA;
    do_reset();
    for (int i = 0; i < WORD_W - 1; i++) begin
      drive(w[i], i == 0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);  // unqualified bit with sync: ignored
      if (i == 15) begin
        n_cmp++; if (bit_cnt !== 5'd16) begin n_bad++; $display("FAIL gaps_cnt16: got %0d want 16", bit_cnt); end
      end
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL gaps_early_valid: got %b want 0", word_valid); end
    drive(w[WORD_W-1], 1'b0, 1'b1, 1'b0);
    n_cmp++; if (word !== 31'h2AAA_AAAA || word_valid !== 1'b1) begin
      n_bad++; $display("FAIL gaps_word: got %h/%b want %h/1", word, word_valid, 31'h2AAA_AAAA);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_bits(31'h7FFF_FFFF, 0, 9, 1'b1, 1'b0);
    n_cmp++; if (bit_cnt !== 5'd10) begin n_bad++; $display("FAIL ferr_cnt10: got %0d want 10", bit_cnt); end
    // Bit 0 of 31'h1 carrying a sync while 10 bits are pending.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (frame_err !== 1'b1 || bit_cnt !== 5'd1) begin
      n_bad++; $display("FAIL ferr_pulse: frame_err %b bit_cnt %0d want 1 1", frame_err, bit_cnt);
    end
    send_bits(31'h0000_0001, 1, 1, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_one_cycle: got %b want 0", frame_err); end
    send_bits(31'h0000_0001, 2, 30, 1'b0, 1'b0);
    n_cmp++; if (word !== 31'h0000_0001 || word_valid !== 1'b1) begin
      n_bad++; $display("FAIL ferr_word: got %h/%b want 00000001/1", word, word_valid);
    end
    // Sync at a word boundary in LOCK is a normal start (bit 0 of 2AAAAAAA is 0).
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (frame_err !== 1'b0 || bit_cnt !== 5'd1) begin
      n_bad++; $display("FAIL ferr_boundary_sync: frame_err %b bit_cnt %0d want 0 1", frame_err, bit_cnt);
    end
    send_bits(31'h2AAA_AAAA, 1, 30, 1'b0, 1'b0);
    n_cmp++; if (word !== 31'h2AAA_AAAA) begin n_bad++; $display("FAIL ferr_next_word: got %h want %h", word, 31'h2AAA_AAAA); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_bits(31'h1234_5678, 0, 30, 1'b1, 1'b0);
    n_cmp++; if (word !== 31'h1234_5678) begin n_bad++; $display("FAIL ovr_first_word: got %h want %h", word, 31'h1234_5678); end
    send_bits(31'h7FFF_FFFF, 0, 30, 1'b0, 1'b0);
    n_cmp++; if (word !== 31'h7FFF_FFFF || overrun !== 1'b1 || word_valid !== 1'b1) begin
      n_bad++; $display("FAIL ovr_second: word %h overrun %b valid %b want 7fffffff 1 1", word, overrun, word_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (overrun !== 1'b1 || word_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovr_sticky: overrun %b valid %b want 1 0", overrun, word_valid);
    end
  endtask

  task automatic test_back_to_back_ack();
    do_reset();
    send_bits(31'h1234_5678, 0, 30, 1'b1, 1'b0);
    send_bits(31'h7FFF_FFFF, 0, 30, 1'b0, 1'b1);
    n_cmp++; if (word !== 31'h7FFF_FFFF || overrun !== 1'b0 || word_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ack: word %h overrun %b valid %b want 7fffffff 0 1", word, overrun, word_valid);
    end
  endtask

`ifdef SHIFT_DESER_ERRCNT_EN
  task automatic test_errcnt();
    do_reset();
    expected_word = 31'h1234_5678;
    send_bits(31'h1234_5678, 0, 30, 1'b1, 1'b1);
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL errcnt_match: got %0d want 0", err_cnt); end
    send_bits(31'h1234_5679, 0, 30, 1'b0, 1'b1);
    send_bits(31'h1234_5678, 0, 30, 1'b0, 1'b1);
    n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL errcnt_one: got %0d want 1", err_cnt); end
  endtask
`endif

  task automatic test_reset_mid_word();
    do_reset();
    send_bits(31'h1234_5678, 0, 30, 1'b1, 1'b0);
    send_bits(31'h1234_5678, 0, 30, 1'b0, 1'b0);
`ifdef SHIFT_DESER_ERRCNT_EN
    expected_word = 31'h0;
    send_bits(31'h1234_5678, 0, 30, 1'b0, 1'b0);
`endif
    send_bits(31'h7FFF_FFFF, 0, 9, 1'b0, 1'b0);
    // Asynchronous reset in the middle of a clock period.
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (word !== 31'h0 || word_valid !== 1'b0 || overrun !== 1'b0 || bit_cnt !== 5'd0 || frame_err !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: word %h valid %b overrun %b cnt %0d ferr %b want all 0",
                        word, word_valid, overrun, bit_cnt, frame_err);
    end
`ifdef SHIFT_DESER_ERRCNT_EN
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL midreset_err_cnt: got %0d want 0", err_cnt); end
`endif
    @(posedge qzt_clk);
    #1;
    reset = 1'b0;
    // Back in HUNT: bits without sync must not be collected.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bit_cnt !== 5'd0) begin n_bad++; $display("FAIL midreset_hunt: bit_cnt got %0d want 0", bit_cnt); end
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    sync      = 1'b0;
    word_ack  = 1'b0;
`ifdef SHIFT_DESER_ERRCNT_EN
    expected_word = 31'h0;
`endif
    test_reset();
    test_hunt();
    test_basic();
    test_gaps();
    test_frame_err();
    test_overrun();
    test_back_to_back_ack();
`ifdef SHIFT_DESER_ERRCNT_EN
    test_errcnt();
`endif
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
